// File: rtl/encoder83_seq.sv
// Sequential 8-to-3 priority encoder with a pending-request register and a valid/ready output handshake.
// Latency: a load seen at one edge is presented after that edge. With ready high, one code is accepted per cycle.
module encoder83_seq #(
  parameter int LOW_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       ready,
  output logic [2:0] result,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       collide
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] result_q, result_d;
  logic [3:0] cnt_q, cnt_d;
  logic       collide_q, collide_d;

  logic       handshake;
  logic [7:0] accept_mask;
  logic [7:0] load_vec;

  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LOW_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  always_comb begin
    handshake   = (state_q == PRESENT) && ready;
    accept_mask = handshake ? (8'b1 << result_q) : 8'h00;
    load_vec    = load ? data_in : 8'h00;
    // A bit reloaded on the edge it is accepted stays pending and is not a collision.
    pend_d      = (pend_q & ~accept_mask) | load_vec;
    collide_d   = |(load_vec & pend_q & ~accept_mask);
    cnt_d       = popcount(pend_d);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (pend_d != 8'h00) begin
          state_d  = PRESENT;
          result_d = prio(pend_d);
        end
      end
      PRESENT: begin
        // Without a handshake the presented code is frozen, even if higher-priority bits arrive.
        if (handshake) begin
          if (pend_d != 8'h00) begin
            result_d = prio(pend_d);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 8'h00;
      result_q  <= 3'd0;
      cnt_q     <= 4'd0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
    end
  end

  assign result   = result_q;
  assign valid    = (state_q == PRESENT);
  assign pend_cnt = cnt_q;
  assign collide  = collide_q;

endmodule

// File: tb/tb_encoder83_seq.sv
// Scoreboard bench: the stimulus pushes hand-computed codes, and a negedge monitor pops them on each valid/ready handshake.
module tb_encoder83_seq;

  typedef struct {
    int res;
    int cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in0, data_in1;
  logic       load0, load1, ready0, ready1;
  logic [2:0] result0, result1;
  logic       valid0, valid1, collide0, collide1;
  logic [3:0] pend_cnt0, pend_cnt1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_cmp;
  int   n_fail;
  int   collide_seen;
  int   collide_base;

  encoder83_seq #(.LOW_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in0), .load(load0), .ready(ready0),
    .result(result0), .valid(valid0), .pend_cnt(pend_cnt0), .collide(collide0)
  );

  encoder83_seq #(.LOW_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in1), .load(load1), .ready(ready1),
    .result(result1), .valid(valid1), .pend_cnt(pend_cnt1), .collide(collide1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int r, input int c);
    exp_t e;
    e.res = r;
    e.cnt = c;
    q0.push_back(e);
  endtask

  task automatic push1(input int r, input int c);
    exp_t e;
    e.res = r;
    e.cnt = c;
    q1.push_back(e);
  endtask

  // Monitor: a handshake occurs on the next rising edge whenever valid && ready at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid0 && ready0) begin
          if (q0.size() == 0) chk("dut0_unexpected_code", int'(result0), -1);
          else begin
            e0 = q0.pop_front();
            chk("dut0_result", int'(result0), e0.res);
            chk("dut0_pend_cnt", int'(pend_cnt0), e0.cnt);
          end
        end
        if (valid1 && ready1) begin
          if (q1.size() == 0) chk("dut1_unexpected_code", int'(result1), -1);
          else begin
            e1 = q1.pop_front();
            chk("dut1_result", int'(result1), e1.res);
            chk("dut1_pend_cnt", int'(pend_cnt1), e1.cnt);
          end
        end
        if (collide0) collide_seen++;
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    collide_seen = 0;
    rst_n = 1'b0;
    data_in0 = 8'h00; load0 = 1'b0; ready0 = 1'b0;
    data_in1 = 8'h00; load1 = 1'b0; ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(valid0), 0);
    chk("reset_result", int'(result0), 0);
    chk("reset_pend_cnt", int'(pend_cnt0), 0);
    chk("reset_collide", int'(collide0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: presented one edge after the load, then drained.
    load0 = 1'b1; data_in0 = 8'b0010_0000; ready0 = 1'b1;
    push0(5, 1);
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    chk("single_valid", int'(valid0), 1);
    tick();
    chk("single_drained_valid", int'(valid0), 0);
    chk("single_drained_cnt", int'(pend_cnt0), 0);

    // Multi-hot, high index first.
    load0 = 1'b1; data_in0 = 8'b1000_0101;
    push0(7, 3); push0(2, 2); push0(0, 1);
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    repeat (3) tick();
    chk("hi_first_done_valid", int'(valid0), 0);

    // Multi-hot, low index first.
    load1 = 1'b1; data_in1 = 8'b1000_0101; ready1 = 1'b1;
    push1(0, 3); push1(2, 2); push1(7, 1);
    tick();
    load1 = 1'b0; data_in1 = 8'h00;
    repeat (3) tick();
    chk("lo_first_done_valid", int'(valid1), 0);
    ready1 = 1'b0;

    // Stall: a higher-priority arrival must not displace the presented code.
    ready0 = 1'b0; load0 = 1'b1; data_in0 = 8'h04;
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    chk("stall_valid", int'(valid0), 1);
    chk("stall_result", int'(result0), 2);
    chk("stall_cnt", int'(pend_cnt0), 1);
    load0 = 1'b1; data_in0 = 8'h80;
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    chk("stall_hold_result", int'(result0), 2);
    chk("stall_hold_cnt", int'(pend_cnt0), 2);
    chk("stall_no_collide", int'(collide0), 0);
    push0(2, 2); push0(7, 1);
    ready0 = 1'b1;
    repeat (2) tick();
    chk("stall_done_valid", int'(valid0), 0);

    // Back-to-back one-hot sweep at full throughput.
    collide_base = collide_seen;
    for (int i = 0; i < 8; i++) begin
      load0 = 1'b1; data_in0 = 8'h01 << i;
      push0(i, 1);
      tick();
    end
    load0 = 1'b0; data_in0 = 8'h00;
    tick();
    chk("sweep_done_valid", int'(valid0), 0);
    chk("sweep_collide_count", collide_seen - collide_base, 0);

    // Reload of the bit being accepted: it stays pending, no collision.
    load0 = 1'b1; data_in0 = 8'h08;
    push0(3, 1); push0(3, 1);
    tick();
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    chk("reload_collide", int'(collide0), 0);
    chk("reload_valid", int'(valid0), 1);
    chk("reload_result", int'(result0), 3);
    tick();
    chk("reload_done_valid", int'(valid0), 0);

    // load with an empty vector changes nothing.
    ready0 = 1'b0; load0 = 1'b1; data_in0 = 8'h02;
    tick();
    data_in0 = 8'h00;
    tick();
    load0 = 1'b0;
    chk("empty_load_cnt", int'(pend_cnt0), 1);
    chk("empty_load_collide", int'(collide0), 0);
    chk("empty_load_result", int'(result0), 1);
    push0(1, 1);
    ready0 = 1'b1;
    tick();
    chk("empty_load_done", int'(valid0), 0);

    // Collision on a pending bit, then asynchronous reset while pending.
    ready0 = 1'b0; load0 = 1'b1; data_in0 = 8'h10;
    tick();
    chk("coll_first_collide", int'(collide0), 0);
    chk("coll_result", int'(result0), 4);
    tick();
    load0 = 1'b0; data_in0 = 8'h00;
    chk("coll_pulse", int'(collide0), 1);
    chk("coll_cnt", int'(pend_cnt0), 1);
    tick();
    chk("coll_pulse_end", int'(collide0), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(valid0), 0);
    chk("arst_result", int'(result0), 0);
    chk("arst_cnt", int'(pend_cnt0), 0);
    chk("arst_collide", int'(collide0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready0 = 1'b1;
    repeat (2) tick();
    chk("post_reset_valid", int'(valid0), 0);
    chk("post_reset_cnt", int'(pend_cnt0), 0);

    chk("dut0_queue_left", q0.size(), 0);
    chk("dut1_queue_left", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
